// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the execute stage.
// One engine handles MULT, MULTU, DIV and DIVU on operand magnitudes and
// applies the result signs on the final step. Multiply is shift-add (LSB
// first), divide is restoring (MSB first), both one bit per cycle.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; hi/lo/dbz hold the last completed result
// S_RUN  | iterating; counter runs WIDTH-1 down to 0
// S_DONE | ready cycle; hi/lo/dbz valid, start accepted back-to-back
module mdu_iter #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dbz_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;          // product / quotient sign
  logic               neg_rem_q, neg_rem_d;  // remainder sign
  logic [WIDTH-1:0]   opnd_q, opnd_d;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;    // partial product high / remainder
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;    // multiplier / quotient shift reg
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] fast_prod, fast_fix;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               q_bit;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Next-state, datapath step and result sign correction
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    a_neg = ~op_i[0] & a_i[WIDTH-1];
    b_neg = ~op_i[0] & b_i[WIDTH-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;

    fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    fast_fix  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;

    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    q_bit     = (div_shift >= {1'b0, opnd_q});

    if (is_div_q) begin
      step_hi = q_bit ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], q_bit};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end

    prod_mag = {step_hi, step_lo};
    prod_fix = neg_q ? -prod_mag : prod_mag;
    quo_fix  = neg_q ? -step_lo : step_lo;
    rem_fix  = neg_rem_q ? -step_hi : step_hi;

    // annul beats start; start is ignored while iterating
    accept = start_i && !annul_i && (state_q != S_RUN);

    case (state_q)
      S_RUN: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = S_DONE;
            dbz_d   = 1'b0;
            if (is_div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      is_div_d  = op_i[1];
      neg_d     = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      if (op_i[1] && (b_i == '0)) begin
        state_d = S_DONE;
        hi_d    = a_i;
        lo_d    = '1;
        dbz_d   = 1'b1;
      end else if (FAST_MUL && !op_i[1]) begin
        state_d = S_DONE;
        hi_d    = fast_fix[2*WIDTH-1:WIDTH];
        lo_d    = fast_fix[WIDTH-1:0];
        dbz_d   = 1'b0;
      end else begin
        state_d  = S_RUN;
        cnt_d    = CW'(WIDTH - 1);
        opnd_d   = op_i[1] ? b_mag : a_mag;
        acc_hi_d = '0;
        acc_lo_d = op_i[1] ? a_mag : b_mag;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy_o  = (state_q == S_RUN);
  assign ready_o = (state_q == S_DONE);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign dbz_o   = dbz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: an iterative instance and a fast-multiply instance.
// Stimulus pushes expected results (with the cycle ready must appear in)
// into a per-instance queue; a negedge monitor pops and compares.
module tb_mdu_iter;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [1:0]  op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        annul0 = 1'b0, annul1 = 1'b0;
  logic        busy0, rdy0, dbz0, busy1, rdy1, dbz1;
  logic [31:0] hi0, lo0, hi1, lo1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];

  mdu_iter #(.WIDTH(32), .FAST_MUL(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .op_i(op0), .a_i(a0), .b_i(b0),
    .annul_i(annul0), .busy_o(busy0), .ready_o(rdy0), .hi_o(hi0), .lo_o(lo0), .dbz_o(dbz0)
  );

  mdu_iter #(.WIDTH(32), .FAST_MUL(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .op_i(op1), .a_i(a1), .b_i(b1),
    .annul_i(annul1), .busy_o(busy1), .ready_o(rdy1), .hi_o(hi1), .lo_o(lo1), .dbz_o(dbz1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rdy0) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_ready", 64'd1, 64'd0);
      end else begin
        e = q0.pop_front();
        chk("dut0_hi", {32'd0, hi0}, {32'd0, e.hi});
        chk("dut0_lo", {32'd0, lo0}, {32'd0, e.lo});
        chk("dut0_dbz", {63'd0, dbz0}, {63'd0, e.dbz});
        chk("dut0_ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (rst_n && rdy1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_ready", 64'd1, 64'd0);
      end else begin
        e = q1.pop_front();
        chk("dut1_hi", {32'd0, hi1}, {32'd0, e.hi});
        chk("dut1_lo", {32'd0, lo1}, {32'd0, e.lo});
        chk("dut1_dbz", {63'd0, dbz1}, {63'd0, e.dbz});
        chk("dut1_ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Drive one start for a cycle; lat is edges from accept to the ready cycle
  task automatic issue(input bit fast, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit want, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic edbz, input int lat);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dbz = edbz; e.cyc = cyc + 1 + lat;
    if (fast) begin
      start1 = 1'b1; op1 = op; a1 = a; b1 = b;
      if (want) q1.push_back(e);
    end else begin
      start0 = 1'b1; op0 = op; a0 = a; b0 = b;
      if (want) q0.push_back(e);
    end
    advance();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_ready(input bit fast, input string name);
    for (int i = 0; i < 40; i++) begin
      if (fast ? rdy1 : rdy0) return;
      advance();
    end
    chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    repeat (3) advance();
    chk("reset_busy", {63'd0, busy0}, 64'd0);
    chk("reset_ready", {63'd0, rdy0}, 64'd0);
    chk("reset_hi", {32'd0, hi0}, 64'd0);
    chk("reset_lo", {32'd0, lo0}, 64'd0);
    chk("reset_dbz", {63'd0, dbz0}, 64'd0);
    rst_n = 1'b1;
    advance();

    // Fast-multiply instance
    issue(1, MULT, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
    chk("fast_busy", {63'd0, busy1}, 64'd0);
    wait_ready(1, "fast_mult");
    advance();
    issue(1, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    advance();
    issue(1, DIV, 32'd7, 32'd0, 1, 32'd7, 32'hFFFF_FFFF, 1'b1, 0);
    advance();
    issue(1, DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0, 32);
    wait_ready(1, "fast_divu");
    advance();
    issue(1, MULTU, 32'd2, 32'd3, 1, 32'd0, 32'd6, 1'b0, 0);
    issue(1, MULT, 32'hFFFF_FFFF, 32'd5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 0);
    advance();

    // Iterative signed multiply with busy window
    issue(0, MULT, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32);
    chk("mult_busy_c1", {63'd0, busy0}, 64'd1);
    chk("mult_ready_c1", {63'd0, rdy0}, 64'd0);
    repeat (31) advance();
    chk("mult_busy_c32", {63'd0, busy0}, 64'd1);
    advance();
    chk("mult_busy_c33", {63'd0, busy0}, 64'd0);
    chk("mult_ready_c33", {63'd0, rdy0}, 64'd1);
    advance();

    // Divides
    issue(0, DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0, 32);
    wait_ready(0, "divu"); advance();
    issue(0, DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32);
    wait_ready(0, "div_neg"); advance();
    issue(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, 1'b0, 32);
    wait_ready(0, "div_ovf"); advance();
    issue(0, DIVU, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 32'hFFFF_FFFF, 1'b0, 32);
    wait_ready(0, "divu_max"); advance();

    // Divide by zero then a multiply clears dbz
    issue(0, DIV, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b1, 0);
    chk("dbz_busy", {63'd0, busy0}, 64'd0);
    wait_ready(0, "dbz"); advance();
    issue(0, MULTU, 32'd2, 32'd3, 1, 32'd0, 32'd6, 1'b0, 32);
    wait_ready(0, "multu_small"); advance();

    // Annul mid-operation
    issue(0, DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0, 32);
    wait_ready(0, "divu_pre_annul"); advance();
    issue(0, DIV, 32'd1000, 32'd3, 0, '0, '0, 1'b0, 0);
    repeat (9) advance();
    annul0 = 1'b1;
    advance();
    annul0 = 1'b0;
    chk("annul_busy_c11", {63'd0, busy0}, 64'd0);
    chk("annul_hi", {32'd0, hi0}, 64'd2);
    chk("annul_lo", {32'd0, lo0}, 64'd14);
    repeat (40) advance();
    chk("annul_hi_held", {32'd0, hi0}, 64'd2);

    // Annul together with start in idle
    start0 = 1'b1; annul0 = 1'b1; op0 = DIVU; a0 = 32'd50; b0 = 32'd5;
    advance();
    start0 = 1'b0; annul0 = 1'b0;
    chk("annul_start_busy", {63'd0, busy0}, 64'd0);
    advance();
    chk("annul_start_ready", {63'd0, rdy0}, 64'd0);
    advance();

    // Start ignored while busy, then back-to-back start in the ready cycle
    issue(0, MULTU, 32'h1234_5678, 32'h10, 1, 32'h1, 32'h2345_6780, 1'b0, 32);
    repeat (4) advance();
    start0 = 1'b1; op0 = DIVU; a0 = 32'd9; b0 = 32'd9;
    advance();
    start0 = 1'b0;
    repeat (27) advance();
    chk("b2b_ready_c33", {63'd0, rdy0}, 64'd1);
    issue(0, MULT, 32'hFFFF_FFFF, 32'h8000_0000, 1, 32'd0, 32'h8000_0000, 1'b0, 32);
    chk("b2b_busy", {63'd0, busy0}, 64'd1);
    wait_ready(0, "b2b"); advance();
    issue(0, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32);
    wait_ready(0, "multu_max"); advance();
    issue(0, DIVU, 32'd9, 32'd0, 1, 32'd9, 32'hFFFF_FFFF, 1'b1, 0);
    advance();

    // Reset mid-operation
    issue(0, DIV, 32'd50, 32'd3, 0, '0, '0, 1'b0, 0);
    repeat (4) advance();
    rst_n = 1'b0;
    advance();
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_hi", {32'd0, hi0}, 64'd0);
    chk("rst_lo", {32'd0, lo0}, 64'd0);
    chk("rst_dbz", {63'd0, dbz0}, 64'd0);
    rst_n = 1'b1;
    repeat (40) advance();
    chk("rst_no_ready", {63'd0, rdy0}, 64'd0);

    chk("dut0_queue_empty", 64'(q0.size()), 64'd0);
    chk("dut1_queue_empty", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit serving the execute stage of the pipelined MIPS core. It replaces the fixed 32-bit divider with one engine for MULT, MULTU, DIV and DIVU, with a configurable width and an optional single-cycle multiply mode. It produces a HI/LO pair and a one-cycle `ready` pulse. The hazard unit holds the pipeline on `busy`, and exception flush cancels an operation in flight through `annul`.

## Interface
- `WIDTH`, 32: operand width. Must be even and ≥ 4. HI and LO are each `WIDTH` bits.
- `FAST_MUL`, 0: 0 = iterative shift-add multiply; 1 = multiply result registered after one cycle.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `start`  in  1  request a new operation; sampled only when idle or in DONE.
- `op`  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a`  in  WIDTH  multiplicand / dividend; captured when `start` is accepted.
- `b`  in  WIDTH  multiplier / divisor; captured when `start` is accepted.
- `annul`  in  1  cancel any operation in flight (exception flush).
- `busy`  out  1  high while an operation is in progress (RUN state).
- `ready`  out  1  one-cycle pulse; HI/LO are valid in this cycle.
- `hi`  out  WIDTH  product upper half, or remainder.
- `lo`  out  WIDTH  product lower half, or quotient.
- `dbz`  out  1  divide-by-zero flag for the last completed operation.

## Operation
- **States:**
  - IDLE → RUN on an accepted `start`.
  - RUN → DONE when the iteration counter reaches 0.
  - DONE → IDLE next cycle, or DONE → RUN if `start` is asserted that cycle (back-to-back).
- **Start acceptance:** `start` is ignored in RUN. When accepted, operands, `op` and sign flags are latched and the counter is loaded with `WIDTH`-1.
- **Signed ops:** the engine works on operand magnitudes and fixes signs at the end.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- **Multiply:** produces the full 2·`WIDTH`-bit two's-complement product. `hi` = upper half, `lo` = lower half.
- **Divide:** restoring algorithm, one quotient bit per cycle. `lo` = quotient and `hi` = remainder, both truncated toward zero.
- **Overflow case:** DIV of -2^(`WIDTH`-1) by -1 gives `lo` = -2^(`WIDTH`-1) (wraps) and `hi` = 0.
- **Divide by zero** (`b` = 0, op DIV or DIVU):
  - No iteration; goes straight to DONE.
  - `hi` = `a` and `lo` = all ones.
  - `dbz` = 1.
- **Fast multiply:** with `FAST_MUL` = 1, MULT/MULTU go straight to DONE with the product registered.
- **Flag and result registers:**
  - `dbz` is updated on every `ready` pulse and is held otherwise.
  - `hi`/`lo` update only on the `ready` cycle and hold until the next completion.
- **Annul:**
  - Returns the unit to IDLE on the next edge.
  - No `ready` is issued, and `hi`/`lo`/`dbz` are unchanged.
  - If `annul` and `start` arrive in the same cycle, `annul` wins and `start` is dropped.
  - `annul` in IDLE has no effect.
- **Reset:** `rst` = 0 at an edge forces IDLE with `busy` = 0, `ready` = 0, `hi` = 0, `lo` = 0, `dbz` = 0. This overrides everything, including an operation in flight.

## Timing
- `start` is accepted at edge 0.
- **Iterative path:**
  - `busy` = 1 for cycles 1..`WIDTH`.
  - `ready` = 1 in cycle `WIDTH`+1 with `busy` = 0.
  - Latency is `WIDTH`+1 cycles (33 for `WIDTH` = 32).
- **Divide-by-zero and fast-multiply paths:** `ready` = 1 in cycle 1 and `busy` never rises.
- **Back-to-back:** `start` during the `ready` cycle is accepted, so the next operation has no bubble.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **`busy` feeds the stall logic:** the pipeline holds E while `busy` = 1, and the next HI/LO consumer reads `hi`/`lo` on or after the `ready` cycle.

## Test plan
1. **Signed multiply, iterative:** `WIDTH` = 32, `FAST_MUL` = 0, MULT a = -3, b = 7.
   - Required: `busy` high in cycles 1–32; `ready` in cycle 33 with `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
   - Repeat with `FAST_MUL` = 1: same values with `ready` in cycle 1.
2. **Unsigned and signed divide:**
   - DIVU 100/7 → `lo` = 14, `hi` = 2, `dbz` = 0.
   - DIV -7/2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
   - DIV 0x80000000/0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
3. **Divide by zero:** DIV a = 5, b = 0.
   - Required: `ready` in cycle 1, `dbz` = 1, `hi` = 5, `lo` = 0xFFFFFFFF.
   - Following MULTU 2×3 → `dbz` = 0, `lo` = 6, `hi` = 0.
4. **Annul mid-operation:** DIVU 100/7 completes first, then DIV starts and `annul` is pulsed in cycle 10.
   - Required: `busy` = 0 in cycle 11, no `ready`, `hi` = 2 and `lo` = 14 retained.
   - `annul` together with `start` in IDLE → no operation begins.
5. **Start ignored while busy; back-to-back accepted:**
   - `start` pulsed in cycle 5 of a MULTU is ignored; the original result appears in cycle 33.
   - `start` in the `ready` cycle begins the next operation immediately, with its `ready` 33 cycles later.
6. **Reset mid-operation:** `rst` = 0 in cycle 5 of a DIV.
   - Required: next edge `busy` = 0, `hi` = `lo` = 0, `dbz` = 0, and no `ready` afterward.
